// File: rtl/gate_ex_pkg.sv
// Shared definitions for the gate exerciser: FSM state encodings, vector count, result widths.
package gate_ex_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int NVEC  = 4;
    localparam int ERR_W = 3;

endpackage

// File: rtl/gate_ex_check.sv
// Truth-table checker for the and/or/not gate trio.
// Latency: combinational.
// Backpressure: none.
module gate_ex_check (
    input  logic x,
    input  logic y,
    input  logic a_in,
    input  logic o_in,
    input  logic n_in,
    output logic mismatch
);

    assign mismatch = (a_in != (x & y)) || (o_in != (x | y)) || (n_in != ~x);

endmodule

// File: rtl/gate_exerciser.sv
// Walks the four x/y vectors, holding each for HOLD cycles, and scores the returned gate outputs.
// Latency: done rises 4*HOLD+1 cycles after the cycle that accepts start.
// Backpressure: none; start is accepted only in IDLE or DONE, ignored while driving.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter int HOLD = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    input  logic             a_in,
    input  logic             o_in,
    input  logic             n_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_idx,
    output logic [1:0]       vec_idx
);

    localparam int CNT_W = $clog2(HOLD) + 1;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             first_fail;
    logic             last_hold;
    logic             mismatch;

    gate_ex_check u_check (
        .x        (x),
        .y        (y),
        .a_in     (a_in),
        .o_in     (o_in),
        .n_in     (n_in),
        .mismatch (mismatch)
    );

    // Gate outputs are only trusted on the final cycle of each hold window.
    assign last_hold = (hold_cnt == CNT_W'(HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            vec_idx    <= '0;
            x          <= 1'b0;
            y          <= 1'b0;
            err_count  <= '0;
            fail_idx   <= '0;
            first_fail <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        hold_cnt   <= '0;
                        vec_idx    <= '0;
                        x          <= 1'b0;
                        y          <= 1'b0;
                        err_count  <= '0;
                        fail_idx   <= '0;
                        first_fail <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (last_hold) begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (!first_fail) begin
                                fail_idx   <= vec_idx;
                                first_fail <= 1'b1;
                            end
                        end
                        if (vec_idx != 2'(NVEC - 1)) begin
                            vec_idx  <= vec_idx + 2'd1;
                            hold_cnt <= '0;
                            {x, y}   <= vec_idx + 2'd1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_DRIVE);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: table of gate-fault runs plus reset and HOLD=1 sequences.
module tb_gate_exerciser;

    localparam int HOLD = 5;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       x, y, a_in, o_in, n_in;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] fail_idx, vec_idx;

    logic       rst1, start1;
    logic       x1, y1, busy1, done1, pass1;
    logic [2:0] err_count1;
    logic [1:0] fail_idx1, vec_idx1;

    int fault;
    int cyc;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gate_exerciser #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .a_in(a_in), .o_in(o_in), .n_in(n_in),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx), .vec_idx(vec_idx)
    );

    gate_exerciser #(.HOLD(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .x(x1), .y(y1),
        .a_in(x1 & y1), .o_in(x1 | y1), .n_in(~x1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_idx(fail_idx1), .vec_idx(vec_idx1)
    );

    // Gate model with injectable faults; mode 5 corrupts every non-final hold cycle.
    always_comb begin
        a_in = x & y;
        o_in = x | y;
        n_in = ~x;
        case (fault)
            1: a_in = 1'b0;
            2: n_in = 1'b1;
            3: o_in = 1'b0;
            4: begin a_in = ~a_in; o_in = ~o_in; n_in = ~n_in; end
            5: if (cyc % HOLD != 0) begin a_in = ~a_in; o_in = ~o_in; n_in = ~n_in; end
            default: ;
        endcase
    end

    typedef struct {
        int         fault;
        int         restart_at;
        logic [2:0] err;
        logic [1:0] fidx;
        logic       pss;
    } run_t;

    run_t runs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_one(input run_t r);
        fault = r.fault;
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4 * HOLD; c++) begin
            cyc = c;
            #1;
            chk("busy_run", int'(busy), 1);
            chk("done_run", int'(done), 0);
            chk("xy_run", int'({x, y}), (c - 1) / HOLD);
            chk("vec_idx_run", int'(vec_idx), (c - 1) / HOLD);
            if (c == r.restart_at) start = 1'b1;
            step();
            start = 1'b0;
        end
        cyc = 0;
        chk("done_end", int'(done), 1);
        chk("busy_end", int'(busy), 0);
        chk("pass_end", int'(pass), int'(r.pss));
        chk("err_count_end", int'(err_count), int'(r.err));
        chk("fail_idx_end", int'(fail_idx), int'(r.fidx));
        chk("xy_end", int'({x, y}), 3);
        step();
        chk("done_hold", int'(done), 1);
        chk("err_count_hold", int'(err_count), int'(r.err));
    endtask

    initial begin
        runs[0] = '{0, 0, 3'd0, 2'd0, 1'b1};
        runs[1] = '{1, 0, 3'd1, 2'd3, 1'b0};
        runs[2] = '{2, 0, 3'd2, 2'd2, 1'b0};
        runs[3] = '{3, 0, 3'd3, 2'd1, 1'b0};
        runs[4] = '{4, 0, 3'd4, 2'd0, 1'b0};
        runs[5] = '{5, 0, 3'd0, 2'd0, 1'b1};
        runs[6] = '{0, 8, 3'd0, 2'd0, 1'b1};
        runs[7] = '{0, 0, 3'd0, 2'd0, 1'b1};

        fault  = 0;
        cyc    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        rst1   = 1'b1;
        start1 = 1'b0;
        step();
        step();

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_xy", int'({x, y}), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_fail_idx", int'(fail_idx), 0);
        chk("rst_vec_idx", int'(vec_idx), 0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        step();
        chk("rst_over_start_busy", int'(busy), 0);

        foreach (runs[i]) run_one(runs[i]);

        // Reset in cycle 7 of a run that has already recorded a failure.
        fault = 4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        chk("mid_err_before_rst", int'(err_count), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_xy", int'({x, y}), 0);
        chk("mid_rst_vec_idx", int'(vec_idx), 0);
        chk("mid_rst_err", int'(err_count), 0);
        chk("mid_rst_done", int'(done), 0);
        for (int c = 0; c < 10; c++) step();
        chk("idle_stays_busy", int'(busy), 0);
        chk("idle_stays_done", int'(done), 0);
        fault = 0;

        // HOLD=1 instance: a new vector every cycle, done in cycle 5.
        rst1 = 1'b0;
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("h1_busy", int'(busy1), 1);
            chk("h1_xy", int'({x1, y1}), c - 1);
            step();
        end
        chk("h1_done", int'(done1), 1);
        chk("h1_busy_end", int'(busy1), 0);
        chk("h1_pass", int'(pass1), 1);
        chk("h1_err", int'(err_count1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
